cla_15bit_checker: RTL

CLA_15BIT_CHECKER -- requirements
Module: cla_15bit_checker

---
 rtl/cla_15bit_checker.sv | 125 ++++++++++++
 1 files changed

// File: rtl/cla_15bit_checker.sv
// rtl/cla_15bit_checker.sv - self-checking harness comparing a 15-bit adder's results against a reference sum
module cla_15bit_checker (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  vec_count,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [14:0] A,
    input  logic [14:0] B,
    input  logic        mode,
    input  logic [14:0] S,
    input  logic        Cout,
    input  logic        Ovf,
    output logic [7:0]  pass_cnt,
    output logic [7:0]  fail_cnt,
    output logic        first_fail_valid,
    output logic [7:0]  first_fail_idx,
    output logic [2:0]  first_fail_flags,
    output logic        done
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

    state_t      state, state_next;
    logic [7:0]  vec_cnt_r;
    logic [7:0]  acc_cnt;
    logic        accept;
    logic        start_ok;

    logic        cmp_valid;
    logic [14:0] a_r, b_r, s_r;
    logic        mode_r, cout_r, ovf_r;
    logic [7:0]  idx_r;

    logic [14:0] bx;
    logic [15:0] sum_exp;
    logic        ovf_exp;
    logic [2:0]  flags;

    assign in_ready = (state == ST_RUN);
    assign done     = (state == ST_DONE);
    assign accept   = in_ready && in_valid;
    assign start_ok = start && ((state == ST_IDLE) || (state == ST_DONE));

    // Reference result is derived from the registered vector, one cycle after acceptance.
    assign bx      = b_r ^ {15{mode_r}};
    assign sum_exp = {1'b0, a_r} + {1'b0, bx} + {15'd0, mode_r};
    assign ovf_exp = (a_r[14] == bx[14]) && (sum_exp[14] != a_r[14]);
    assign flags   = {s_r != sum_exp[14:0], cout_r != sum_exp[15], ovf_r != ovf_exp};

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_next = (vec_count == 8'd0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept && (acc_cnt == vec_cnt_r - 8'd1)) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: state_next = ST_DONE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ST_IDLE;
            vec_cnt_r        <= 8'd0;
            acc_cnt          <= 8'd0;
            cmp_valid        <= 1'b0;
            a_r              <= 15'd0;
            b_r              <= 15'd0;
            s_r              <= 15'd0;
            mode_r           <= 1'b0;
            cout_r           <= 1'b0;
            ovf_r            <= 1'b0;
            idx_r            <= 8'd0;
            pass_cnt         <= 8'd0;
            fail_cnt         <= 8'd0;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= 8'd0;
            first_fail_flags <= 3'd0;
        end else begin
            state     <= state_next;
            cmp_valid <= accept;
            if (accept) begin
                a_r     <= A;
                b_r     <= B;
                s_r     <= S;
                mode_r  <= mode;
                cout_r  <= Cout;
                ovf_r   <= Ovf;
                idx_r   <= acc_cnt;
                acc_cnt <= acc_cnt + 8'd1;
            end
            // No compare can be pending in IDLE/DONE, so a start never races a counter update.
            if (start_ok) begin
                vec_cnt_r        <= vec_count;
                acc_cnt          <= 8'd0;
                pass_cnt         <= 8'd0;
                fail_cnt         <= 8'd0;
                first_fail_valid <= 1'b0;
                first_fail_idx   <= 8'd0;
                first_fail_flags <= 3'd0;
            end else if (cmp_valid) begin
                if (flags == 3'd0) begin
                    pass_cnt <= pass_cnt + 8'd1;
                end else begin
                    fail_cnt <= fail_cnt + 8'd1;
                    if (!first_fail_valid) begin
                        first_fail_valid <= 1'b1;
                        first_fail_idx   <= idx_r;
                        first_fail_flags <= flags;
                    end
                end
            end
        end
    end

endmodule
